// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, 8 data bits
// LSB first, odd parity, stop bit and device acknowledge, with a frame timeout.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 2500,
    parameter int unsigned TIMEOUT_CYCLES = 375000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned FRAME_W = 10;
    localparam int unsigned BIT_W   = 4;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_RTS       = 3'd2;
    localparam logic [2:0] S_SEND      = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    logic [2:0]         state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [FRAME_W-1:0] shreg, shreg_n;
    logic [BIT_W-1:0]   bitcnt, bitcnt_n;
    logic               clk_oe_n, data_oe_n, done_n, error_n, ready_n;

    logic clk_s1, clk_s2, clk_d, fall;
    logic data_s1, data_s2;
    logic timeout_c;

    // Two-flop synchronizers on both pins plus a registered falling-edge pulse on the clock
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_d   <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
            fall    <= 1'b0;
        end else begin
            clk_s1  <= ps2_clk_in;
            clk_s2  <= clk_s1;
            clk_d   <= clk_s2;
            data_s1 <= ps2_data_in;
            data_s2 <= data_s1;
            fall    <= clk_d & ~clk_s2;
        end
    end

    assign timeout_c = (cnt == CW'(TIMEOUT_CYCLES - 1));

    // State, frame and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            shreg       <= '1;
            bitcnt      <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            shreg       <= shreg_n;
            bitcnt      <= bitcnt_n;
            ps2_clk_oe  <= clk_oe_n;
            ps2_data_oe <= data_oe_n;
            tx_done     <= done_n;
            tx_error    <= error_n;
            tx_ready    <= ready_n;
            busy        <= ~ready_n;
        end
    end

    // Next-state and next-output logic; line enables follow the state being entered
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        shreg_n   = shreg;
        bitcnt_n  = bitcnt;
        clk_oe_n  = 1'b0;
        data_oe_n = ps2_data_oe;
        done_n    = 1'b0;
        error_n   = 1'b0;

        case (state)
            S_IDLE: begin
                data_oe_n = 1'b0;
                if (tx_valid && tx_ready) begin
                    state_n  = S_INHIBIT;
                    cnt_n    = '0;
                    shreg_n  = {1'b1, ~^tx_data, tx_data};
                    bitcnt_n = '0;
                    clk_oe_n = 1'b1;
                end
            end
            S_INHIBIT: begin
                clk_oe_n  = 1'b1;
                data_oe_n = 1'b0;
                if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
                    state_n   = S_RTS;
                    data_oe_n = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_RTS: begin
                state_n   = S_SEND;
                cnt_n     = '0;
                data_oe_n = 1'b1;
            end
            S_SEND: begin
                cnt_n = cnt + CW'(1);
                if (timeout_c) begin
                    state_n   = S_IDLE;
                    data_oe_n = 1'b0;
                    error_n   = 1'b1;
                end else if (fall) begin
                    shreg_n   = {1'b0, shreg[FRAME_W-1:1]};
                    data_oe_n = ~shreg[0];
                    bitcnt_n  = bitcnt + BIT_W'(1);
                    if (bitcnt == BIT_W'(9)) begin
                        state_n = S_ACK;
                    end
                end
            end
            S_ACK: begin
                cnt_n     = cnt + CW'(1);
                data_oe_n = 1'b0;
                if (timeout_c) begin
                    state_n = S_IDLE;
                    error_n = 1'b1;
                end else if (fall) begin
                    if (!data_s2) begin
                        state_n = S_WAIT_IDLE;
                    end else begin
                        state_n = S_IDLE;
                        error_n = 1'b1;
                    end
                end
            end
            S_WAIT_IDLE: begin
                cnt_n     = cnt + CW'(1);
                data_oe_n = 1'b0;
                if (timeout_c) begin
                    state_n = S_IDLE;
                    error_n = 1'b1;
                end else if (clk_s2 && data_s2) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n   = S_IDLE;
                data_oe_n = 1'b0;
            end
        endcase

        ready_n = (state_n == S_IDLE);
    end

endmodule
